// File: rtl/tmr_fault_monitor_pkg.sv
// Shared types and helpers for the TMR fault monitor: lane state encoding,
// lane count and the per-bit majority vote.
package tmr_mon_pkg;

  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {
    LANE_OK      = 2'b00,
    LANE_SUSPECT = 2'b01,
    LANE_FAILED  = 2'b10
  } lane_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_fault_monitor_lane_tracker.sv
// Health tracker for one replica lane: OK/SUSPECT/FAILED state, consecutive
// mismatch run counter and a saturating total-mismatch counter.
module tmr_lane_tracker
  import tmr_mon_pkg::*;
#(
  parameter int fail_thresh = 4,
  parameter int cnt_width   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 mismatch,
  input  logic                 force_fail,
  output lane_state_t          state,
  output logic [cnt_width-1:0] err_cnt,
  output logic                 fail_entry
);

  logic [7:0]  run;
  logic [7:0]  run_next;
  logic [8:0]  run_inc;
  lane_state_t state_next;

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + {{(cnt_width-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_next = state;
    run_next   = run;
    run_inc    = {1'b0, run} + 9'd1;
    if (force_fail) begin
      state_next = LANE_FAILED;
    end else if (enable) begin
      case (state)
        LANE_OK: begin
          if (mismatch) begin
            run_next   = 8'd1;
            state_next = (fail_thresh <= 1) ? LANE_FAILED : LANE_SUSPECT;
          end
        end
        LANE_SUSPECT: begin
          if (!mismatch) begin
            state_next = LANE_OK;
            run_next   = '0;
          end else begin
            run_next = run_inc[7:0];
            if (run_inc >= 9'(fail_thresh)) state_next = LANE_FAILED;
          end
        end
        default: ;
      endcase
    end
  end

  // A lane already FAILED cannot re-enter; clear suppresses the entry event.
  assign fail_entry = !clear && (state != LANE_FAILED) && (state_next == LANE_FAILED);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state   <= LANE_OK;
      run     <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_next;
      run   <= run_next;
      if (enable && mismatch && state != LANE_FAILED) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Voter and health monitor for a triplicated count interface. Optional
// force_fail input is enabled by defining TMR_MON_FORCE_FAIL_EN.
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int width       = 8,
  parameter int fail_thresh = 4,
  parameter int cnt_width   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [width-1:0]     q_1,
  input  logic [width-1:0]     q_2,
  input  logic [width-1:0]     q_3,
  input  logic                 clear,
`ifdef TMR_MON_FORCE_FAIL_EN
  input  logic [2:0]           force_fail,
`endif
  output logic [width-1:0]     voted_q,
  output logic [2:0]           fault_flags,
  output logic [5:0]           lane_state,
  output logic [cnt_width-1:0] err_cnt_1,
  output logic [cnt_width-1:0] err_cnt_2,
  output logic [cnt_width-1:0] err_cnt_3,
  output logic                 uncorrectable,
  output logic                 irq
);

  lane_state_t            st         [NUM_LANES];
  logic [cnt_width-1:0]   err        [NUM_LANES];
  logic [width-1:0]       lane_q     [NUM_LANES];
  logic [NUM_LANES-1:0]   healthy;
  logic [NUM_LANES-1:0]   mismatch;
  logic [NUM_LANES-1:0]   fail_entry;
  logic [NUM_LANES-1:0]   force_bits;
  logic [width-1:0]       maj_q;
  logic [width-1:0]       vote_next;
  logic [width-1:0]       pair_a;
  logic [width-1:0]       pair_b;
  logic                   unc_next;

`ifdef TMR_MON_FORCE_FAIL_EN
  assign force_bits = force_fail;
`else
  assign force_bits = '0;
`endif

  assign lane_q[0] = q_1;
  assign lane_q[1] = q_2;
  assign lane_q[2] = q_3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmr_lane_tracker #(
      .fail_thresh (fail_thresh),
      .cnt_width   (cnt_width)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (clear),
      .mismatch   (mismatch[i]),
      .force_fail (force_bits[i]),
      .state      (st[i]),
      .err_cnt    (err[i]),
      .fail_entry (fail_entry[i])
    );
    assign healthy[i]          = (st[i] != LANE_FAILED);
    assign lane_state[2*i +: 2] = st[i];
  end

  assign err_cnt_1 = err[0];
  assign err_cnt_2 = err[1];
  assign err_cnt_3 = err[2];

  always_comb begin
    maj_q = '0;
    for (int b = 0; b < width; b++) maj_q[b] = maj3(q_1[b], q_2[b], q_3[b]);
  end

  // With two healthy lanes, pair_a/pair_b are those two lanes in index order.
  assign pair_a = healthy[0] ? q_1 : q_2;
  assign pair_b = healthy[2] ? q_3 : q_2;

  always_comb begin
    vote_next = voted_q;
    unc_next  = 1'b0;
    mismatch  = '0;
    case (healthy)
      3'b111: begin
        if (q_1 == q_2 || q_1 == q_3) begin
          vote_next = q_1;
        end else if (q_2 == q_3) begin
          vote_next = q_2;
        end else begin
          vote_next = maj_q;
          unc_next  = 1'b1;
        end
        for (int i = 0; i < NUM_LANES; i++) mismatch[i] = (lane_q[i] != vote_next);
      end
      3'b011, 3'b101, 3'b110: begin
        if (pair_a == pair_b) begin
          vote_next = pair_a;
        end else begin
          unc_next = 1'b1;
          mismatch = healthy;
        end
      end
      3'b001: vote_next = q_1;
      3'b010: vote_next = q_2;
      3'b100: vote_next = q_3;
      default: unc_next = 1'b1;
    endcase
  end

  // Output register stage: vote result, flags and the health event pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_q       <= '0;
      fault_flags   <= '0;
      uncorrectable <= 1'b0;
      irq           <= 1'b0;
    end else if (clear) begin
      fault_flags   <= '0;
      uncorrectable <= 1'b0;
      irq           <= 1'b0;
    end else begin
      irq <= (|fail_entry) || (enable && unc_next && !uncorrectable);
      if (enable) begin
        voted_q       <= vote_next;
        fault_flags   <= mismatch;
        uncorrectable <= unc_next;
      end
    end
  end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: directed samples push hand-computed
// expectations; a monitor pops and compares one entry after each clock edge.
module tb_tmr_fault_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] q_1 = '0, q_2 = '0, q_3 = '0;
  logic [7:0] voted_q;
  logic [2:0] fault_flags;
  logic [5:0] lane_state;
  logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3;
  logic       uncorrectable;
  logic       irq;

  typedef struct {
    int         id;
    logic [7:0] vq;
    logic [2:0] ff;
    logic       chk_ff;
    logic [5:0] ls;
    logic [7:0] e1, e2, e3;
    logic       unc;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tmr_fault_monitor #(.width(8), .fail_thresh(4), .cnt_width(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .q_1           (q_1),
    .q_2           (q_2),
    .q_3           (q_3),
    .clear         (clear),
    .voted_q       (voted_q),
    .fault_flags   (fault_flags),
    .lane_state    (lane_state),
    .err_cnt_1     (err_cnt_1),
    .err_cnt_2     (err_cnt_2),
    .err_cnt_3     (err_cnt_3),
    .uncorrectable (uncorrectable),
    .irq           (irq)
  );

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("voted_q", e.id, voted_q, e.vq);
      if (e.chk_ff) chk("fault_flags", e.id, {5'b0, fault_flags}, {5'b0, e.ff});
      chk("lane_state", e.id, {2'b0, lane_state}, {2'b0, e.ls});
      chk("err_cnt_1", e.id, err_cnt_1, e.e1);
      chk("err_cnt_2", e.id, err_cnt_2, e.e2);
      chk("err_cnt_3", e.id, err_cnt_3, e.e3);
      chk("uncorrectable", e.id, {7'b0, uncorrectable}, {7'b0, e.unc});
      chk("irq", e.id, {7'b0, irq}, {7'b0, e.irq});
    end
  end

  int step_id = 0;

  task automatic step(input logic r, input logic en, input logic cl,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] vq, input logic [2:0] ff, input logic chk_ff,
                      input logic [5:0] ls, input logic [7:0] e1, input logic [7:0] e2,
                      input logic [7:0] e3, input logic unc, input logic ir);
    exp_t e;
    @(negedge clk);
    rst = r; enable = en; clear = cl; q_1 = a; q_2 = b; q_3 = c;
    step_id++;
    e.id = step_id; e.vq = vq; e.ff = ff; e.chk_ff = chk_ff; e.ls = ls;
    e.e1 = e1; e.e2 = e2; e.e3 = e3; e.unc = unc; e.irq = ir;
    sb.push_back(e);
  endtask

  initial begin
    // reset held two cycles
    step(1,0,0, 8'h00,8'h00,8'h00, 8'h00,3'b000,1, 6'b000000, 0,0,0, 0,0);
    step(1,0,0, 8'h00,8'h00,8'h00, 8'h00,3'b000,1, 6'b000000, 0,0,0, 0,0);
    // clean sample
    step(0,1,0, 8'h05,8'h05,8'h05, 8'h05,3'b000,1, 6'b000000, 0,0,0, 0,0);
    // transient fault on lane 2, then recovery
    step(0,1,0, 8'h10,8'hFF,8'h10, 8'h10,3'b010,1, 6'b000100, 0,1,0, 0,0);
    step(0,1,0, 8'h11,8'h11,8'h11, 8'h11,3'b000,1, 6'b000000, 0,1,0, 0,0);
    // persistent fault on lane 3
    step(0,1,0, 8'h10,8'h10,8'h33, 8'h10,3'b100,1, 6'b010000, 0,1,1, 0,0);
    step(0,1,0, 8'h10,8'h10,8'h33, 8'h10,3'b100,1, 6'b010000, 0,1,2, 0,0);
    step(0,1,0, 8'h10,8'h10,8'h33, 8'h10,3'b100,1, 6'b010000, 0,1,3, 0,0);
    step(0,1,0, 8'h10,8'h10,8'h33, 8'h10,3'b100,1, 6'b100000, 0,1,4, 0,1);
    step(0,0,0, 8'h10,8'h10,8'h33, 8'h10,3'b100,1, 6'b100000, 0,1,4, 0,0);
    step(0,1,0, 8'h10,8'h10,8'h33, 8'h10,3'b000,1, 6'b100000, 0,1,4, 0,0);
    // masked disagreement between the two healthy lanes
    step(0,1,0, 8'h20,8'h21,8'h33, 8'h10,3'b011,1, 6'b100101, 1,2,4, 1,1);
    step(0,0,0, 8'h20,8'h21,8'h33, 8'h10,3'b011,1, 6'b100101, 1,2,4, 1,0);
    // clear alone
    step(0,0,1, 8'h20,8'h21,8'h33, 8'h10,3'b000,0, 6'b000000, 0,0,0, 0,0);
    // no majority: bitwise vote of 0C/0A/09 is 08
    step(0,1,0, 8'h0C,8'h0A,8'h09, 8'h08,3'b111,1, 6'b010101, 1,1,1, 1,1);
    // clear with enable: sample discarded, vote held
    step(0,1,1, 8'h0C,8'h0A,8'h09, 8'h08,3'b000,0, 6'b000000, 0,0,0, 0,0);
    // reset mid-operation
    step(0,1,0, 8'h10,8'hFF,8'h10, 8'h10,3'b010,1, 6'b000100, 0,1,0, 0,0);
    step(1,1,0, 8'h10,8'hFF,8'h10, 8'h00,3'b000,1, 6'b000000, 0,0,0, 0,0);
    step(0,1,0, 8'h05,8'h05,8'h05, 8'h05,3'b000,1, 6'b000000, 0,0,0, 0,0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Receiving end of the triplicated count interface: consumes the three replica values q_1/q_2/q_3 from a TMR counter group.
- Produces a registered voted value and tracks per-lane health with a small FSM.
- Masks lanes that have persistently failed and reports uncorrectable disagreement.
- Sits between the TMR counter group and downstream logic or status registers; raises a one-cycle irq on health events.

Parameters:
- width, 8, bit width of each replica value
- fail_thresh, 4, consecutive mismatching samples before a lane is declared FAILED (range 1..255)
- cnt_width, 8, width of the per-lane saturating error counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  sample strobe; q_1/q_2/q_3 are evaluated only when high
- q_1  in  width  replica lane 1
- q_2  in  width  replica lane 2
- q_3  in  width  replica lane 3
- clear  in  1  returns all lanes to OK and zeroes all counters
- voted_q  out  width  registered voted value
- fault_flags  out  3  registered per-lane mismatch of the last sample (bit0 = lane 1)
- lane_state  out  6  2 bits per lane: 00 OK, 01 SUSPECT, 10 FAILED
- err_cnt_1, err_cnt_2, err_cnt_3  out  cnt_width  total mismatches per lane, saturating at all-ones
- uncorrectable  out  1  registered; last sample had no valid majority
- irq  out  1  one-cycle pulse

Behaviour:
- Reset/clock: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: voted_q=0, fault_flags=0, lane_state=0 (all OK), err_cnt_*=0, uncorrectable=0, irq=0, internal run counters=0.
- Latency: all outputs are registered. A sample taken with enable=1 at edge N is visible after edge N. With enable=0, all state holds and irq=0.
- Vote, healthy set = lanes not FAILED:
  - 3 healthy, at least two lanes equal: output the equal value; uncorrectable=0.
  - 3 healthy, all distinct: output the bitwise majority (a&b)|(a&c)|(b&c); uncorrectable=1.
  - 2 healthy, equal: output that value; uncorrectable=0.
  - 2 healthy, different: hold the previous voted_q; uncorrectable=1.
  - 1 healthy: pass that lane through; uncorrectable=0.
  - 0 healthy: hold voted_q; uncorrectable=1.
- Mismatch: a healthy lane mismatches when its value differs from the vote computed in the same cycle. In the "hold" cases, every healthy lane is flagged. FAILED lanes are never flagged and their err_cnt is frozen.
- Lane FSM, per enabled sample:
  - OK + mismatch -> SUSPECT, run=1.
  - SUSPECT + match -> OK, run=0.
  - SUSPECT + mismatch -> run+1; when run reaches fail_thresh -> FAILED.
  - With fail_thresh=1, OK + mismatch goes straight to FAILED.
  - FAILED is sticky until clear or rst.
- err_cnt_x: increments on every flagged sample; saturates at 2^cnt_width-1, no wrap.
- irq: high for exactly one cycle when any lane enters FAILED or uncorrectable rises 0->1. Simultaneous events produce a single pulse.
- clear: takes effect at the next edge. Lane states -> OK, run and err counters -> 0, uncorrectable=0, irq=0, voted_q held. clear and enable together: clear wins and the sample is discarded.
- rst has priority over clear; rst asserted mid-operation returns all state to reset values at the next edge.

Optional Feature:
- Macro TMR_MON_FORCE_FAIL_EN.
- Defined: adds input force_fail (3 bits). An asserted bit drives the corresponding lane to FAILED at the next edge regardless of enable. This counts as a FAILED entry for irq. clear wins over force_fail in the same cycle.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package tmr_mon_pkg holds:
  - lane_state_t enum: LANE_OK=2'b00, LANE_SUSPECT=2'b01, LANE_FAILED=2'b10
  - NUM_LANES=3
  - a majority-vote function
- Sub-module tmr_lane_tracker: one per lane, instantiated three times. Contains the lane FSM, run counter and saturating err counter. Inputs: enable, clear, mismatch, force_fail. Outputs: state, err_cnt, fail_entry.
- The vote and healthy-set logic stay in the top.

Test Plan (width=8, fail_thresh=4, cnt_width=8):
- Reset: rst=1 for 2 cycles -> all outputs 0, lane_state=6'b000000, irq=0.
- Clean sample: enable=1, all lanes 0x05 -> next cycle voted_q=0x05, fault_flags=000, err counters unchanged.
- Transient fault: one sample with q_2=0xFF and lanes 1/3=0x10, then all lanes 0x11.
  - After first sample: voted_q=0x10, fault_flags=010, lane 2 SUSPECT, err_cnt_2=1.
  - After second sample: lane 2 OK, err_cnt_2 still 1.
- Persistent fault: q_3 differs from lanes 1/2 for 4 consecutive samples -> lane 3 FAILED after the 4th, irq pulses exactly once, err_cnt_3=4. A further mismatching sample leaves err_cnt_3=4 and fault_flags[2]=0.
- Masked disagreement: with lane 3 FAILED and voted_q=0x10, set q_1=0x20, q_2=0x21 -> voted_q stays 0x10, uncorrectable=1, fault_flags=011, one irq pulse.
- No majority: after clear, q_1=0x0C, q_2=0x0A, q_3=0x09 -> voted_q=0x08, uncorrectable=1, fault_flags=111. Then assert clear and enable in the same cycle -> all lanes OK, err counters 0, voted_q holds 0x08.
